// File: rtl/mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared constants for the multiply/divide unit: op encodings as issued by EX,
// the controller FSM state codes, the divider step count and a small helper
// for taking operand magnitudes.
// -----------------------------------------------------------------------------
package mdu_ctrl_pkg;

  // Operation codes on the op input; bit 1 selects divide, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  // One quotient bit is produced per step.
  localparam int MDU_DIV_STEPS = 32;

  // Magnitude of a 32-bit operand. For signed ops the two's complement of a
  // negative value is taken; 0x80000000 maps onto itself, which is the correct
  // unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Restoring radix-2 unsigned divider core, one quotient bit per clock.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   load                 capture dividend/divisor magnitudes, clear counter
//   step                 perform one shift/trial-subtract iteration
//   dividend, divisor    unsigned operand magnitudes (sampled on load)
//   quot, rem            current quotient / partial remainder
//   last_step            high while the final iteration is being performed
// -----------------------------------------------------------------------------
module div_iter
  import mdu_ctrl_pkg::*;
#(
  parameter int DIV_STEPS = MDU_DIV_STEPS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        last_step
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  logic [31:0]   divisor_q;
  logic [31:0]   rem_q;
  logic [31:0]   quot_q;
  logic [CW-1:0] count_q;
  logic [32:0]   rem_shift;
  logic [32:0]   trial;

  // Shift the next dividend bit into the remainder and trial-subtract the
  // divisor. The partial remainder is always below the divisor, so the shifted
  // value fits 33 bits and bit 32 of the difference is a reliable borrow.
  always_comb begin
    rem_shift = {rem_q, quot_q[31]};
    trial     = rem_shift - {1'b0, divisor_q};
  end

  // The quotient register doubles as the dividend shift register: dividend
  // bits leave at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      count_q   <= '0;
    end else if (load) begin
      divisor_q <= divisor;
      rem_q     <= '0;
      quot_q    <= dividend;
      count_q   <= '0;
    end else if (step) begin
      if (!trial[32]) begin
        rem_q  <= trial[31:0];
        quot_q <= {quot_q[30:0], 1'b1};
      end else begin
        rem_q  <= rem_shift[31:0];
        quot_q <= {quot_q[30:0], 1'b0};
      end
      count_q <= count_q + 1'b1;
    end
  end

  assign quot      = quot_q;
  assign rem       = rem_q;
  assign last_step = (count_q == CW'(DIV_STEPS - 1));

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide controller owning the architectural HI/LO registers.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start, op            MULT/MULTU/DIV/DIVU request from EX (held while stalled)
//   rs_val, rt_val       multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata    direct HI/LO writes
//   flush                abort whatever is in flight, suppress HI/LO writes
//   stall                holds IF..EX while an operation is outstanding
//   done                 one-cycle pulse in the commit cycle
//   hi, lo               architectural HI/LO
// -----------------------------------------------------------------------------
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DIV_STEPS = MDU_DIV_STEPS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q;
  logic [31:0] rs_q, rt_q;
  logic [63:0] prod_q;
  logic        accept;
  logic        load_div;
  logic        step_div;
  logic        div_last;
  logic        mul_signed;
  logic        div_signed;
  logic [31:0] div_quot, div_rem;
  logic [31:0] quot_fix, rem_fix;
  logic [63:0] result;

  assign accept   = (state_q == S_IDLE) && start && !flush;
  assign load_div = accept && op[1];
  assign step_div = (state_q == S_DIV) && !flush;

  div_iter #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load_div),
    .step      (step_div),
    .dividend  (mag32(rs_val, ~op[0])),
    .divisor   (mag32(rt_val, ~op[0])),
    .quot      (div_quot),
    .rem       (div_rem),
    .last_step (div_last)
  );

  // Next-state and handshake outputs. Flush overrides everything: it kills the
  // stall so EX can be replaced and it vetoes the commit.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = op[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall   = 1'b1;
        state_d = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        if (div_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      stall   = 1'b0;
      done    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Raw operands and op are kept for the multiplier and the sign fix-up; they
  // only change when a new operation is accepted, so the held EX instruction
  // cannot disturb an operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q <= MDU_MULT;
      rs_q <= '0;
      rt_q <= '0;
    end else if (accept) begin
      op_q <= mdu_op_e'(op);
      rs_q <= rs_val;
      rt_q <= rt_val;
    end
  end

  assign mul_signed = (op_q == MDU_MULT);
  assign div_signed = (op_q == MDU_DIV);

  // Single-cycle multiply: sign- or zero-extend both operands to 64 bits so one
  // truncated 64x64 product serves both MULT and MULTU.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod_q <= '0;
    end else if (state_q == S_MUL) begin
      prod_q <= {{32{mul_signed & rs_q[31]}}, rs_q} * {{32{mul_signed & rt_q[31]}}, rt_q};
    end
  end

  // The quotient is negative when the operand signs differ and the remainder
  // follows the dividend; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  always_comb begin
    quot_fix = (div_signed && (rs_q[31] ^ rt_q[31])) ? (~div_quot + 32'd1) : div_quot;
    rem_fix  = (div_signed && rs_q[31]) ? (~div_rem + 32'd1) : div_rem;
    result   = op_q[1] ? {rem_fix, quot_fix} : prod_q;
  end

  // HI/LO: a commit takes priority over a simultaneous MTHI/MTLO; a flush
  // suppresses every write to the architectural registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= result[63:32];
      lo <= result[31:0];
    end else if (!flush) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide controller owning the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from the EX stage, sequences a single-cycle-issue multiplier and a 32-step iterative divider, and stalls the pipeline until the result commits. It sits beside the ALU in EX. The decoder's `hilowen`/`hiloren` select which instructions reach it.

## Interface
- `DIV_STEPS`, 32: divider iterations, one quotient bit per cycle.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  EX holds a valid MULT/MULTU/DIV/DIVU; held high by the stalled pipeline.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  multiplicand / dividend.
- `rt_val`  in  32  multiplier / divisor.
- `mthi`, `mtlo`  in  1  write HI / LO from `wdata`.
- `wdata`  in  32  MTHI/MTLO data.
- `flush`  in  1  exception/ERET flush of EX; aborts the operation.
- `stall`  out  1  holds IF..EX.
- `done`  out  1  one-cycle pulse when the result commits.
- `hi`, `lo`  out  32  architectural HI/LO.

## Operation
- FSM states:
  - IDLE:
    - `start & ~flush` latches operands and op.
    - MULT/MULTU goes to MUL; DIV/DIVU goes to DIV with counter = 0.
  - MUL: registered 64-bit product (signed or unsigned per op), then DONE.
  - DIV:
    - Restoring radix-2 on operand magnitudes (signed ops take abs value; unsigned use the raw value).
    - Each cycle: shift {rem, quot} left, trial-subtract the divisor, set the quotient bit.
    - Counter increments; after `DIV_STEPS` steps, go to DONE.
  - DONE:
    - Commit at the clock edge: MUL writes HI = prod[63:32], LO = prod[31:0]; DIV writes LO = quotient, HI = remainder.
    - `done` = 1, then return to IDLE.
- Signed divide:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero is defined as the natural restoring result: LO = 0xFFFFFFFF and HI = |dividend| for unsigned; the sign rules are then applied for DIV. No exception.
- `start` is ignored in MUL, DIV and DONE, which covers the same instruction still held in EX.
- MTHI/MTLO write at the clock edge in any state except an active commit. If it coincides with a DONE commit, the MDU result wins.
- `flush` in any state: next state IDLE, no HI/LO write, `done` stays 0, in-flight data is discarded.
- HI/LO reads are direct register outputs; there is no bypass of an in-flight result.

## Timing
- Reset: state IDLE, `hi` = `lo` = 0, `done` = 0, `stall` = 0, counter = 0.
- `stall` = (state == IDLE & `start` & ~`flush`) | state ∈ {MUL, DIV}, with `~flush` applied in all states. `stall` is combinational and low in DONE, so the instruction leaves EX in the commit cycle.
- MULT: `start` in cycle c0 (IDLE), MUL at c1, DONE at c2. `stall` high at c0–c1. HI/LO visible at c3.
- DIV: `start` at c0, DIV at c1..c32, DONE at c33. `stall` high at c0–c32. HI/LO visible at c34.
- Back-to-back operations: a new `start` is accepted only in IDLE, at the earliest the cycle after DONE.
- Asynchronous reset mid-operation: immediate return to the reset values.

## Structure
- Shared `head.vh` constants:
  - op encodings MDU_MULT / MDU_MULTU / MDU_DIV / MDU_DIVU;
  - FSM state codes S_IDLE / S_MUL / S_DIV / S_DONE;
  - DIV_STEPS.
- One sub-module, `div_iter`: the magnitude register, the remainder/quotient shift register, the subtractor and the step counter. `mdu_ctrl` keeps the FSM, the sign fix-up, the product register and HI/LO.

## Test plan
- MULT with rs = 0xFFFFFFFF, rt = 2 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, `stall` high for exactly 2 cycles, `done` at c2. MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV with rs = -7, rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with rs = 100, rt = 7 → LO = 14, HI = 2. `stall` high for 33 cycles, `done` at c33.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- `flush` at DIV step 10 → IDLE next cycle, `stall` low in the flush cycle, HI/LO unchanged, no `done`. A following MULT completes normally.
- MTLO 0x1234 in IDLE → `lo` = 0x1234 next cycle. MTHI coinciding with a DIV DONE → HI = remainder. Assert `resetn` low at DIV step 5 → all outputs return to their reset values immediately.
